// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx_if
// Description : Descriptor handshake and serial output bundle for
//               seq_pattern_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_pattern_tx_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4
);
    logic               start_valid;
    logic               start_ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   reps;
    logic [CNT_W-1:0]   gap;
    logic               idle_bit;
    logic               tick;
    logic               abort;
    logic               x;
    logic               x_valid;
    logic               busy;
    logic               done;

    modport master (
        output start_valid, pattern, len, reps, gap, idle_bit, tick, abort,
        input  start_ready, x, x_valid, busy, done
    );

    modport slave (
        input  start_valid, pattern, len, reps, gap, idle_bit, tick, abort,
        output start_ready, x, x_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial pattern transmitter; emits a captured descriptor
//               MSB-first on x with repeats, inter-repeat gaps and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4
) (
    input  wire              clk,
    input  wire              reset,
    seq_pattern_tx_if.slave  bus
);
    localparam int                c_IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0]  c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [MAX_LEN-1:0]   r_pat;
    logic [c_IDX_W-1:0]   r_last_idx;
    logic [c_IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]     r_reps_left;
    logic [CNT_W-1:0]     r_gap;
    logic [CNT_W-1:0]     r_gap_cnt;
    logic                 r_idle;
    logic                 r_x;
    logic                 r_x_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_start_ready;

    logic [LEN_W-1:0]     w_len_clamped;
    logic [CNT_W-1:0]     w_reps_eff;
    logic [c_IDX_W-1:0]   w_first_idx;
    logic [c_IDX_W-1:0]   w_idx_dec;

    assign w_len_clamped = (bus.len > c_MAX_LEN) ? c_MAX_LEN : bus.len;
    assign w_reps_eff    = (bus.reps == '0) ? c_CNT_ONE : bus.reps;
    // Only meaningful when the clamped length is non-zero.
    assign w_first_idx   = c_IDX_W'(w_len_clamped - LEN_W'(1));
    assign w_idx_dec     = r_idx - c_IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pat         <= '0;
            r_last_idx    <= '0;
            r_idx         <= '0;
            r_reps_left   <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_idle        <= 1'b0;
            r_x           <= 1'b0;
            r_x_valid     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort is deliberately not looked at here.
                    if (bus.start_valid) begin
                        r_pat         <= bus.pattern;
                        r_last_idx    <= w_first_idx;
                        r_reps_left   <= w_reps_eff;
                        r_gap         <= bus.gap;
                        r_idle        <= bus.idle_bit;
                        r_start_ready <= 1'b0;
                        if (w_len_clamped == '0) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_x       <= bus.idle_bit;
                            r_x_valid <= 1'b0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_state   <= S_SEND;
                            r_idx     <= w_first_idx;
                            r_x       <= bus.pattern[w_first_idx];
                            r_x_valid <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    if (bus.abort) begin
                        r_state       <= S_IDLE;
                        r_x           <= r_idle;
                        r_x_valid     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                    end else if (bus.tick) begin
                        if (r_idx != '0) begin
                            r_idx <= w_idx_dec;
                            r_x   <= r_pat[w_idx_dec];
                        end else if (r_reps_left > c_CNT_ONE) begin
                            r_reps_left <= r_reps_left - c_CNT_ONE;
                            r_idx       <= r_last_idx;
                            if (r_gap != '0) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= r_gap;
                                r_x       <= r_idle;
                                r_x_valid <= 1'b0;
                            end else begin
                                r_x <= r_pat[r_last_idx];
                            end
                        end else begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_x       <= r_idle;
                            r_x_valid <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    if (bus.abort) begin
                        r_state       <= S_IDLE;
                        r_x           <= r_idle;
                        r_x_valid     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                    end else if (bus.tick) begin
                        r_gap_cnt <= r_gap_cnt - c_CNT_ONE;
                        if (r_gap_cnt == c_CNT_ONE) begin
                            r_state   <= S_SEND;
                            r_x       <= r_pat[r_idx];
                            r_x_valid <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Leaves on the next edge whether or not abort is high.
                    r_state       <= S_IDLE;
                    r_x           <= r_idle;
                    r_x_valid     <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_start_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.x           = r_x;
    assign bus.x_valid     = r_x_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.start_ready = r_start_ready;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Directed self-checking bench for seq_pattern_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    seq_pattern_tx_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) bus ();

    seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {x_valid, x, done, start_ready, busy}
    logic [4:0] obs;
    assign obs = {bus.x_valid, bus.x, bus.done, bus.start_ready, bus.busy};

    // Overlapping 0110 detector fed straight from x.
    logic [3:0] r_shreg;
    int         r_det_cnt;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            r_shreg   <= 4'b0;
            r_det_cnt <= 0;
        end else if (bus.x_valid) begin
            r_shreg <= {r_shreg[2:0], bus.x};
            if ({r_shreg[2:0], bus.x} == 4'b0110)
                r_det_cnt <= r_det_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] pat, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] g, input logic ib);
        @(posedge clk); #1;
        bus.pattern     = pat;
        bus.len         = l;
        bus.reps        = r;
        bus.gap         = g;
        bus.idle_bit    = ib;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        // Scramble the descriptor: the running transfer must not notice.
        bus.pattern  = ~pat;
        bus.len      = 4'd7;
        bus.reps     = 4'd9;
        bus.gap      = 4'd5;
        bus.idle_bit = ~ib;
    endtask

    // Bit n-1-i of each vector is the expectation for cycle i after acceptance.
    task automatic expect_cycles(input string tag, input int n,
                                 input logic [31:0] xv, input logic [31:0] xs,
                                 input logic [31:0] dn, input logic [31:0] sr,
                                 input logic [31:0] bs, input logic [31:0] tk);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            bus.tick = tk[n-1-i];
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), 32'(obs),
                32'({xv[n-1-i], xs[n-1-i], dn[n-1-i], sr[n-1-i], bs[n-1-i]}));
        end
        bus.tick = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_total         = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.start_valid = 1'b0;
        bus.pattern     = '0;
        bus.len         = '0;
        bus.reps        = '0;
        bus.gap         = '0;
        bus.idle_bit    = 1'b0;
        bus.tick        = 1'b1;
        bus.abort       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", 32'(obs), 32'(5'b00010));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_release", 32'(obs), 32'(5'b00010));

        // Single 0110, idle 1
        send(8'b0000_0110, 4'd4, 4'd1, 4'd0, 1'b1);
        expect_cycles("single", 6, 32'b111100, 32'b011011, 32'b000010,
                      32'b000001, 32'b111100, 32'hFFFF_FFFF);
        #1 chk("single_det", 32'(r_det_cnt), 32'd1);

        // Three back-to-back repeats, no gap
        send(8'b0000_0110, 4'd4, 4'd3, 4'd0, 1'b1);
        expect_cycles("repeat3", 14, 32'b11111111111100, 32'b01100110011011,
                      32'b00000000000010, 32'b00000000000001,
                      32'b11111111111100, 32'hFFFF_FFFF);
        #1 chk("repeat3_det", 32'(r_det_cnt), 32'd4);

        // 101 x2 with gap 2, tick every second cycle, idle 0
        send(8'b0000_0101, 4'd3, 4'd2, 4'd2, 1'b0);
        expect_cycles("gap_tick", 18, 32'b111111000011111100,
                      32'b110011000011001100, 32'b000000000000000010,
                      32'b000000000000000001, 32'b111111111111111100,
                      32'b010101010101010101);

        // len 0: done straight after acceptance
        send(8'hFF, 4'd0, 4'd1, 4'd0, 1'b1);
        expect_cycles("len0", 2, 32'b00, 32'b11, 32'b10, 32'b01, 32'b00, 32'hFFFF_FFFF);

        // len 12 clamps to 8
        send(8'b1011_0010, 4'd12, 4'd1, 4'd0, 1'b0);
        expect_cycles("len_clamp", 10, 32'b1111111100, 32'b1011001000,
                      32'b0000000010, 32'b0000000001, 32'b1111111100,
                      32'hFFFF_FFFF);

        // reps 0 behaves as one repetition (gap never used)
        send(8'b0000_0011, 4'd2, 4'd0, 4'd3, 1'b1);
        expect_cycles("reps0", 4, 32'b1100, 32'b1111, 32'b0010, 32'b0001,
                      32'b1100, 32'hFFFF_FFFF);

        // Abort on the second bit, new descriptor (with abort still high) accepted
        send(8'b0000_0110, 4'd4, 4'd1, 4'd0, 1'b1);
        @(negedge clk);
        chk("abort_bit0", 32'(obs), 32'(5'b10001));
        @(posedge clk); #1 bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_bit1", 32'(obs), 32'(5'b11001));
        @(posedge clk); #1;
        bus.pattern     = 8'b0000_0101;
        bus.len         = 4'd3;
        bus.reps        = 4'd1;
        bus.gap         = 4'd0;
        bus.idle_bit    = 1'b0;
        bus.start_valid = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'(obs), 32'(5'b01010));
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        expect_cycles("after_abort", 5, 32'b11100, 32'b10100, 32'b00010,
                      32'b00001, 32'b11100, 32'hFFFF_FFFF);

        // Asynchronous reset while in GAP
        send(8'b0000_0001, 4'd1, 4'd2, 4'd3, 1'b1);
        @(negedge clk);
        chk("rst_send", 32'(obs), 32'(5'b11001));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_gap", 32'(obs), 32'(5'b01001));
        @(posedge clk); #1 reset = 1'b1;
        #1 chk("rst_async", 32'(obs), 32'(5'b00010));
        @(posedge clk); #1 reset = 1'b0;
        send(8'b0000_0110, 4'd4, 4'd1, 4'd0, 1'b1);
        expect_cycles("post_reset", 6, 32'b111100, 32'b011011, 32'b000010,
                      32'b000001, 32'b111100, 32'hFFFF_FFFF);
        #1 chk("post_reset_det", 32'(r_det_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the source side of the FSM sequence-detector family.
- Accepts a pattern descriptor through a valid/ready handshake: up to MAX_LEN bits, length, repeat count, inter-repeat gap and idle level.
- Emits the pattern MSB-first as a one-bit serial stream `x` that drives a detector's `x` input directly.
- Used as an on-chip stimulus source and as the transmit end of single-wire pattern links.

## Interface
- MAX_LEN, 8, maximum pattern length in bits
- LEN_W, 4, width of `len`; must hold MAX_LEN
- CNT_W, 4, width of `reps` and `gap`
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- start_valid  input  1  descriptor valid
- start_ready  output  1  high exactly when the FSM is in IDLE
- pattern  input  MAX_LEN  pattern bits; bit len-1 is sent first
- len  input  LEN_W  pattern length; 0 sends nothing; values above MAX_LEN are clamped to MAX_LEN
- reps  input  CNT_W  number of repetitions; 0 is treated as 1
- gap  input  CNT_W  idle bit-periods between repetitions
- idle_bit  input  1  level driven on `x` when no pattern bit is being sent
- tick  input  1  bit-period strobe; tie to 1 for one bit per clk
- abort  input  1  synchronous abort of the current transfer
- x  output  1  serial data, registered
- x_valid  output  1  high while `x` carries a pattern bit (SEND state), registered
- busy  output  1  high in SEND or GAP
- done  output  1  one-cycle pulse on normal completion

## Operation
FSM states: IDLE, SEND, GAP, DONE.

- **IDLE**
  - `start_ready`=1.
  - On `start_valid`, capture `pattern`, `len` (clamped), `reps` (0→1), `gap` and `idle_bit`.
  - Go to DONE if captured len==0, else to SEND with bit index = len-1 and repetitions remaining = reps.
  - `abort` is ignored in IDLE; `start_valid` together with `abort` is accepted.
- **SEND**
  - `x` = pattern[index], `x_valid`=1.
  - On `tick`: if index>0, decrement index.
  - On `tick` at index 0:
    - If repetitions remaining >1: decrement it, reload index = len-1, then go to GAP if gap>0, else stay in SEND.
    - Otherwise go to DONE.
- **GAP**
  - `x`=captured idle_bit, `x_valid`=0, gap counter loaded with `gap` on entry.
  - Each `tick` decrements the counter; the `tick` that takes it from 1 to 0 moves to SEND.
- **DONE**
  - `done`=1, `x`=idle_bit, `x_valid`=0.
  - Unconditionally returns to IDLE next edge; `tick` is not required.
- **abort**
  - `abort`=1 in SEND, GAP or DONE moves to IDLE at the next edge.
  - No `done` pulse; `x` returns to idle_bit, `x_valid`=0.
  - `abort` has priority over `tick`.
- **Descriptor inputs** are sampled only at acceptance; later changes have no effect on the running transfer.

## Timing
- **Reset values:** state IDLE, `x`=0, `x_valid`=0, `busy`=0, `done`=0, `start_ready`=1, captured idle_bit=0.
- **Acceptance:** a descriptor is accepted at the edge where start_valid & start_ready. The first pattern bit appears on `x` in the next cycle, with `x_valid`=1.
- **Bit hold:** each bit is held until the edge at which `tick`=1, and changes in the following cycle. With tick≡1 the stream is one bit per clk.
- **Stream length with tick≡1:** total SEND+GAP cycles = reps·len + (reps−1)·gap. Repetitions with gap=0 are back-to-back with no bubble.
- **Completion:** `done` is high for exactly one cycle, in the cycle after the last bit. `start_ready` returns high in the cycle after `done`.
- **Back-to-back throughput:** minimum spacing between accepted descriptors is len·reps + (reps−1)·gap + 2 cycles.
- **len==0:** acceptance is followed by `done` in the next cycle; `x_valid` never asserts.
- **Mid-operation reset:** outputs return to reset values immediately, asynchronously.

## Test plan
- **Single pattern:** pattern=4'b0110, len=4, reps=1, gap=0, tick≡1, idle_bit=1 → `x` = 0,1,1,0 on four consecutive cycles with `x_valid`=1, then `done` for 1 cycle. A 0110 overlapping detector fed from `x` asserts exactly once.
- **Overlapping repeats:** same pattern, reps=3, gap=0 → 12 contiguous valid bits 011001100110, one `done`, total 12 SEND cycles.
- **Gap and tick:** pattern=3'b101, len=3, reps=2, gap=2, tick high every 2nd cycle → each bit held 2 cycles. Sequence is 1,0,1, then two idle periods of `x`=idle_bit with `x_valid`=0, then 1,0,1, then `done`.
- **Boundary values:** len=0 → `done` one cycle after acceptance, `x_valid` never high. len=12 with MAX_LEN=8 → 8 bits sent. reps=0 → behaves as reps=1.
- **Abort:** abort asserted on the 2nd bit → IDLE next edge, no `done`, `start_ready`=1. A new descriptor presented on that same cycle is accepted normally.
- **Reset mid-transfer:** reset asserted during GAP → `x`=0, `x_valid`=0, `busy`=0 immediately. After release, a fresh transfer runs correctly.
